// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_resolve_queue_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int BRQ_DEPTH  = 8;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // One in-flight conditional branch awaiting (or holding) its EX outcome.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    BranchOutcome          prediction;
    BranchOutcome          outcome;
    logic                  resolved;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Alloc / resolve / feedback / redirect bundle of the branch resolve queue.
// master: decode + EX side driving requests; slave: the queue itself.
interface branch_resolve_queue_if #(
  parameter int TAG_W = 3
);
  import branch_resolve_queue_pkg::*;

  logic                  i_alloc_valid;
  logic [ADDR_WIDTH-1:0] i_alloc_pc;
  logic [ADDR_WIDTH-1:0] i_alloc_target;
  BranchOutcome          i_alloc_prediction;
  logic                  o_alloc_ready;
  logic [TAG_W-1:0]      o_alloc_tag;

  logic                  i_res_valid;
  logic [TAG_W-1:0]      i_res_tag;
  BranchOutcome          i_res_outcome;

  logic                  o_fb_valid;
  logic [ADDR_WIDTH-1:0] o_fb_pc;
  BranchOutcome          o_fb_prediction;
  BranchOutcome          o_fb_outcome;

  logic                  o_redirect_valid;
  logic [ADDR_WIDTH-1:0] o_redirect_pc;

  modport master (
    output i_alloc_valid, i_alloc_pc, i_alloc_target, i_alloc_prediction,
    output i_res_valid, i_res_tag, i_res_outcome,
    input  o_alloc_ready, o_alloc_tag,
    input  o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
    input  o_redirect_valid, o_redirect_pc
  );

  modport slave (
    input  i_alloc_valid, i_alloc_pc, i_alloc_target, i_alloc_prediction,
    input  i_res_valid, i_res_tag, i_res_outcome,
    output o_alloc_ready, o_alloc_tag,
    output o_fb_valid, o_fb_pc, o_fb_prediction, o_fb_outcome,
    output o_redirect_valid, o_redirect_pc
  );

endinterface

// File: rtl/branch_resolve_queue_stats.sv
// brq_stats: saturating retire / mispredict counters for the branch
// resolve queue. Only instantiated when BRQ_STATS_EN is defined.
module brq_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic        miss,
  output logic [31:0] o_stat_pred,
  output logic [31:0] o_stat_miss
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Count every retired branch and the retired ones that were mispredicted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_pred <= '0;
      o_stat_miss <= '0;
    end else if (retire) begin
      o_stat_pred <= sat_inc(o_stat_pred);
      if (miss) o_stat_miss <= sat_inc(o_stat_miss);
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks predicted branches from decode until EX
// resolves them, retires them in order as predictor training feedback,
// and issues a redirect plus younger-entry squash on a mispredict.
// Optional feature macro: BRQ_STATS_EN (retire/mispredict counters).
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_queue_if.slave brq,
  input  logic                  i_flush,
  output logic [TAG_W:0]        o_count,
  output logic                  o_err,
  output logic [31:0]           o_stat_pred,
  output logic [31:0]           o_stat_miss
);

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

  brq_entry_t            mem [DEPTH];
  brq_entry_t            head_ent;
  brq_entry_t            res_ent;
  logic [TAG_W:0]        head, tail, count, res_ptr;
  logic [TAG_W-1:0]      head_idx, tail_idx, res_off;
  logic                  empty, full, alloc_fire;
  logic                  res_live, res_ok, res_bad, mispredict, retire;
  logic [ADDR_WIDTH-1:0] recover_pc;
  logic                  redirect_vld_p1;
  logic [ADDR_WIDTH-1:0] redirect_pc_p1;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign count    = tail - head;
  assign empty    = (head == tail);
  assign full     = ((head ^ tail) == {1'b1, {TAG_W{1'b0}}});

  assign alloc_fire = brq.i_alloc_valid & ~full;

  // A tag is live when its distance from head is inside the occupied span;
  // res_ptr is the same entry expressed as a full wrap-bit pointer.
  assign res_ent    = mem[brq.i_res_tag];
  assign res_off    = brq.i_res_tag - head_idx;
  assign res_ptr    = head + {1'b0, res_off};
  assign res_live   = ({1'b0, res_off} < count);
  assign res_ok     = brq.i_res_valid & res_live & ~res_ent.resolved;
  assign res_bad    = brq.i_res_valid & ~res_ok;
  assign mispredict = res_ok & (brq.i_res_outcome != res_ent.prediction);
  assign recover_pc = (res_ent.prediction == TAKEN) ? res_ent.pc + ADDR_WIDTH'(8)
                                                    : res_ent.target;

  // Stale resolved bits can sit beyond tail after a squash, so gate on ~empty.
  assign head_ent = mem[head_idx];
  assign retire   = ~empty & head_ent.resolved;

  assign brq.o_alloc_ready    = ~full;
  assign brq.o_alloc_tag      = tail_idx;
  assign brq.o_fb_valid       = retire;
  assign brq.o_fb_pc          = retire ? head_ent.pc : '0;
  assign brq.o_fb_prediction  = retire ? head_ent.prediction : NOT_TAKEN;
  assign brq.o_fb_outcome     = retire ? head_ent.outcome : NOT_TAKEN;
  assign brq.o_redirect_valid = redirect_vld_p1;
  assign brq.o_redirect_pc    = redirect_pc_p1;
  assign o_count              = count;

  // Entry storage and head/tail pointers; flush beats squash beats plain alloc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].resolved <= 1'b0;
    end else begin
      if (alloc_fire)
        mem[tail_idx] <= '{pc:         brq.i_alloc_pc,
                           target:     brq.i_alloc_target,
                           prediction: brq.i_alloc_prediction,
                           outcome:    NOT_TAKEN,
                           resolved:   1'b0};
      if (res_ok) begin
        mem[brq.i_res_tag].outcome  <= brq.i_res_outcome;
        mem[brq.i_res_tag].resolved <= 1'b1;
      end
      if (retire) head <= head + PTR_ONE;
      if (mispredict)      tail <= res_ptr + PTR_ONE;
      else if (alloc_fire) tail <= tail + PTR_ONE;
    end
  end

  // One-cycle redirect pulse and the sticky bad-resolve flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
      o_err           <= 1'b0;
    end else if (i_flush) begin
      redirect_vld_p1 <= 1'b0;
    end else begin
      redirect_vld_p1 <= mispredict;
      if (mispredict) redirect_pc_p1 <= recover_pc;
      if (res_bad)    o_err <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  brq_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .retire      (retire),
    .miss        (head_ent.prediction != head_ent.outcome),
    .o_stat_pred (o_stat_pred),
    .o_stat_miss (o_stat_miss)
  );
`else
  assign o_stat_pred = '0;
  assign o_stat_miss = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: vector table of single
// branch round trips plus hand-written multi-cycle sequences; feedback
// beats are checked against a scoreboard queue of expected retirements.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic [3:0]  o_count;
  logic        o_err;
  logic [31:0] o_stat_pred, o_stat_miss;

  always #5 clk = ~clk;

  branch_resolve_queue_if #(.TAG_W(3)) bif ();

  branch_resolve_queue #(.DEPTH(8), .TAG_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .brq         (bif),
    .i_flush     (i_flush),
    .o_count     (o_count),
    .o_err       (o_err),
    .o_stat_pred (o_stat_pred),
    .o_stat_miss (o_stat_miss)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic        outc;
  } fb_t;

  typedef struct {
    logic [31:0]  pc;
    logic [31:0]  tgt;
    BranchOutcome pred;
    BranchOutcome outc;
    logic         redir;
    logic [31:0]  rpc;
  } vec_t;

  fb_t  exp_fb [$];
  vec_t vt [5];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_tag  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every feedback beat must match the oldest expected retirement.
  always @(negedge clk) begin
    fb_t e;
    if (rst_n === 1'b1 && bif.o_fb_valid === 1'b1) begin
      if (exp_fb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fb_unexpected: got pc 0x%0h, expected no feedback at %0t", bif.o_fb_pc, $time);
      end else begin
        e = exp_fb.pop_front();
        check("fb_pc", bif.o_fb_pc, e.pc);
        check("fb_pred", 32'(bif.o_fb_prediction), 32'(e.pred));
        check("fb_outcome", 32'(bif.o_fb_outcome), 32'(e.outc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bif.i_alloc_valid = 1'b0;
    bif.i_res_valid   = 1'b0;
    i_flush           = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [31:0] tgt, input BranchOutcome p);
    bif.i_alloc_valid      = 1'b1;
    bif.i_alloc_pc         = pc;
    bif.i_alloc_target     = tgt;
    bif.i_alloc_prediction = p;
    check("alloc_tag", 32'(bif.o_alloc_tag), 32'(exp_tag));
    cyc();
    bif.i_alloc_valid = 1'b0;
    exp_tag = (exp_tag + 1) % 8;
  endtask

  task automatic do_resolve(input int tag, input BranchOutcome o);
    bif.i_res_valid   = 1'b1;
    bif.i_res_tag     = 3'(tag);
    bif.i_res_outcome = o;
    cyc();
    bif.i_res_valid = 1'b0;
  endtask

  task automatic push_fb(input logic [31:0] pc, input BranchOutcome p, input BranchOutcome o);
    exp_fb.push_back(fb_t'{pc: pc, pred: p, outc: o});
  endtask

  // Single branch alloc -> resolve -> retire with redirect check.
  task automatic roundtrip(input logic [31:0] pc, input BranchOutcome p, input BranchOutcome o);
    int t;
    t = exp_tag;
    do_alloc(pc, pc + 32'h40, p);
    push_fb(pc, p, o);
    do_resolve(t, o);
    check("rt_redirect_valid", 32'(bif.o_redirect_valid), 32'(o != p));
    cyc();
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    idle();
    bif.i_alloc_pc = '0; bif.i_alloc_target = '0; bif.i_alloc_prediction = NOT_TAKEN;
    bif.i_res_tag = '0;  bif.i_res_outcome = NOT_TAKEN;

    vt[0] = '{32'h0000_0100, 32'h0000_0140, TAKEN,     TAKEN,     1'b0, 32'h0};
    vt[1] = '{32'h0000_0200, 32'h0000_0180, NOT_TAKEN, TAKEN,     1'b1, 32'h0000_0180};
    vt[2] = '{32'h0000_0300, 32'h0000_0380, TAKEN,     NOT_TAKEN, 1'b1, 32'h0000_0308};
    vt[3] = '{32'h0000_0400, 32'h0000_0480, NOT_TAKEN, NOT_TAKEN, 1'b0, 32'h0};
    vt[4] = '{32'hFFFF_FFF8, 32'h0000_0010, TAKEN,     NOT_TAKEN, 1'b1, 32'h0};

    // Reset state
    #12;
    check("rst_ready", 32'(bif.o_alloc_ready), 32'd1);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_fb_valid", 32'(bif.o_fb_valid), 32'd0);
    check("rst_redirect", 32'(bif.o_redirect_valid), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_tag", 32'(bif.o_alloc_tag), 32'd0);
    check("rst_stat_pred", o_stat_pred, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    // Table of single-branch round trips
    for (int i = 0; i < 5; i++) begin
      t0 = exp_tag;
      do_alloc(vt[i].pc, vt[i].tgt, vt[i].pred);
      push_fb(vt[i].pc, vt[i].pred, vt[i].outc);
      do_resolve(t0, vt[i].outc);
      check("tbl_redirect_valid", 32'(bif.o_redirect_valid), 32'(vt[i].redir));
      if (vt[i].redir) check("tbl_redirect_pc", bif.o_redirect_pc, vt[i].rpc);
      check("tbl_count_resolved", 32'(o_count), 32'd1);
      cyc();
      check("tbl_redirect_pulse", 32'(bif.o_redirect_valid), 32'd0);
      check("tbl_count_retired", 32'(o_count), 32'd0);
    end

    // Mispredict on the oldest of three squashes the two younger ones
    t0 = exp_tag;
    do_alloc(32'h200, 32'h180, NOT_TAKEN);
    do_alloc(32'h204, 32'h280, TAKEN);
    do_alloc(32'h208, 32'h290, TAKEN);
    check("sq_count3", 32'(o_count), 32'd3);
    push_fb(32'h200, NOT_TAKEN, TAKEN);
    do_resolve(t0, TAKEN);
    check("sq_redirect_valid", 32'(bif.o_redirect_valid), 32'd1);
    check("sq_redirect_pc", bif.o_redirect_pc, 32'h180);
    check("sq_count1", 32'(o_count), 32'd1);
    exp_tag = (t0 + 1) % 8;
    cyc();
    check("sq_count0", 32'(o_count), 32'd0);
    cyc();

    // Alloc in the same cycle as a mispredict is accepted then discarded
    t0 = exp_tag;
    do_alloc(32'h500, 32'h580, TAKEN);
    do_alloc(32'h504, 32'h590, TAKEN);
    bif.i_alloc_valid = 1'b1; bif.i_alloc_pc = 32'h510; bif.i_alloc_prediction = TAKEN;
    bif.i_res_valid = 1'b1; bif.i_res_tag = 3'(t0); bif.i_res_outcome = NOT_TAKEN;
    check("sqa_ready", 32'(bif.o_alloc_ready), 32'd1);
    check("sqa_tag", 32'(bif.o_alloc_tag), 32'((t0 + 2) % 8));
    push_fb(32'h500, TAKEN, NOT_TAKEN);
    cyc();
    idle();
    check("sqa_redirect_pc", bif.o_redirect_pc, 32'h508);
    check("sqa_count1", 32'(o_count), 32'd1);
    exp_tag = (t0 + 1) % 8;
    cyc();
    roundtrip(32'h520, NOT_TAKEN, NOT_TAKEN);

    // Resolving an already-resolved entry flags o_err, state unchanged
    t0 = exp_tag;
    do_alloc(32'h600, 32'h640, TAKEN);
    do_alloc(32'h604, 32'h644, TAKEN);
    do_resolve((t0 + 1) % 8, TAKEN);
    check("dr_err0", 32'(o_err), 32'd0);
    check("dr_fb_not_head", 32'(bif.o_fb_valid), 32'd0);
    do_resolve((t0 + 1) % 8, TAKEN);
    check("dr_err1", 32'(o_err), 32'd1);
    check("dr_count", 32'(o_count), 32'd2);
    check("dr_redirect", 32'(bif.o_redirect_valid), 32'd0);
    push_fb(32'h600, TAKEN, TAKEN);
    push_fb(32'h604, TAKEN, TAKEN);
    do_resolve(t0, TAKEN);
    cyc();
    cyc();
    check("dr_count0", 32'(o_count), 32'd0);

    // Asynchronous reset while a feedback beat is pending
    t0 = exp_tag;
    do_alloc(32'h700, 32'h740, TAKEN);
    bif.i_res_valid = 1'b1; bif.i_res_tag = 3'(t0); bif.i_res_outcome = TAKEN;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle();
    #1;
    check("ar_fb_valid", 32'(bif.o_fb_valid), 32'd0);
    check("ar_count", 32'(o_count), 32'd0);
    check("ar_err", 32'(o_err), 32'd0);
    check("ar_ready", 32'(bif.o_alloc_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    exp_tag = 0;
    cyc();

    // Ten retires, three of them mispredicted
    for (int i = 0; i < 10; i++) begin
      roundtrip(32'h800 + 32'(i * 4), (i % 2 == 1) ? TAKEN : NOT_TAKEN,
                (i == 2 || i == 5 || i == 8) ? ((i % 2 == 1) ? NOT_TAKEN : TAKEN)
                                             : ((i % 2 == 1) ? TAKEN : NOT_TAKEN));
    end
`ifdef BRQ_STATS_EN
    check("stat_pred", o_stat_pred, 32'd10);
    check("stat_miss", o_stat_miss, 32'd3);
`else
    check("stat_pred_off", o_stat_pred, 32'd0);
    check("stat_miss_off", o_stat_miss, 32'd0);
`endif

    // Flush to known pointers, then fill to full
    i_flush = 1'b1;
    cyc();
    idle();
    exp_tag = 0;
    check("fl0_count", 32'(o_count), 32'd0);
    for (int k = 0; k < 8; k++) do_alloc(32'h1000 + 32'(k * 4), 32'h2000 + 32'(k * 4), TAKEN);
    check("full_ready", 32'(bif.o_alloc_ready), 32'd0);
    check("full_count", 32'(o_count), 32'd8);
    bif.i_alloc_valid = 1'b1; bif.i_alloc_pc = 32'hDEAD;
    cyc();
    idle();
    check("full_ignored_count", 32'(o_count), 32'd8);
    push_fb(32'h1000, TAKEN, TAKEN);
    do_resolve(0, TAKEN);
    cyc();
    check("full_retire_ready", 32'(bif.o_alloc_ready), 32'd1);
    check("full_retire_count", 32'(o_count), 32'd7);
    do_alloc(32'h3000, 32'h3040, TAKEN);
    check("wrap_count", 32'(o_count), 32'd8);

    // Out-of-order resolves retire in order on consecutive cycles
    push_fb(32'h1004, TAKEN, TAKEN);
    push_fb(32'h1008, TAKEN, TAKEN);
    push_fb(32'h100C, TAKEN, TAKEN);
    do_resolve(3, TAKEN);
    check("ooo_hold3", 32'(bif.o_fb_valid), 32'd0);
    do_resolve(2, TAKEN);
    check("ooo_hold2", 32'(bif.o_fb_valid), 32'd0);
    do_resolve(1, TAKEN);
    check("ooo_fb1", 32'(bif.o_fb_valid), 32'd1);
    cyc();
    check("ooo_fb2", 32'(bif.o_fb_valid), 32'd1);
    cyc();
    check("ooo_fb3", 32'(bif.o_fb_valid), 32'd1);
    cyc();
    check("ooo_done", 32'(bif.o_fb_valid), 32'd0);
    check("ooo_count", 32'(o_count), 32'd5);

    // Flush with live entries wins over same-cycle alloc and resolve
    i_flush = 1'b1;
    bif.i_alloc_valid = 1'b1; bif.i_alloc_pc = 32'hBEEF;
    bif.i_res_valid = 1'b1; bif.i_res_tag = 3'd4; bif.i_res_outcome = NOT_TAKEN;
    cyc();
    idle();
    exp_tag = 0;
    check("flush_count", 32'(o_count), 32'd0);
    check("flush_fb", 32'(bif.o_fb_valid), 32'd0);
    check("flush_redirect", 32'(bif.o_redirect_valid), 32'd0);
    check("flush_ready", 32'(bif.o_alloc_ready), 32'd1);
    check("flush_err", 32'(o_err), 32'd0);
    cyc();

    // Resolve of a free tag sets the sticky error
    do_resolve(5, TAKEN);
    check("free_err", 32'(o_err), 32'd1);
    check("free_count", 32'(o_count), 32'd0);
    check("free_redirect", 32'(bif.o_redirect_valid), 32'd0);
    cyc();
    check("free_err_sticky", 32'(o_err), 32'd1);
    cyc();

    check("fb_all_seen", 32'(exp_fb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
